// File: rtl/gcm_plaintext_release_buffer.sv
// Holds one decrypted GCM message until its tag verdict arrives, then releases it
// to the consumer on a passing verdict or discards it on a failing verdict or timeout.
module gcm_plaintext_release_buffer #(
  parameter int NB_BLOCK    = 128,
  parameter int N_BLOCKS    = 2,
  parameter int NB_DATA     = N_BLOCKS * NB_BLOCK,
  parameter int DEPTH       = 16,
  parameter int TAG_TIMEOUT = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic               i_tag_valid,
  input  logic               i_tag_fail,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_drop,
  output logic               o_overflow,
  output logic               o_lost,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam int W_CNT = $clog2(DEPTH + 1);
  localparam int W_PTR = $clog2(DEPTH);
  localparam int W_TMR = $clog2(TAG_TIMEOUT);

  localparam logic [W_CNT-1:0] CNT_ZERO   = W_CNT'(0);
  localparam logic [W_CNT-1:0] CNT_ONE    = W_CNT'(1);
  localparam logic [W_CNT-1:0] CNT_DEPTH  = W_CNT'(DEPTH);
  localparam logic [W_PTR-1:0] PTR_ZERO   = W_PTR'(0);
  localparam logic [W_PTR-1:0] PTR_ONE    = W_PTR'(1);
  localparam logic [W_TMR-1:0] TMR_ZERO   = W_TMR'(0);
  localparam logic [W_TMR-1:0] TMR_ONE    = W_TMR'(1);
  localparam logic [W_TMR-1:0] TMR_LAST   = W_TMR'(TAG_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WAIT_TAG = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_DISCARD  = 3'd4
  } state_t;

  state_t               state_q;
  logic [W_CNT-1:0]     wr_cnt_q;
  logic [W_PTR-1:0]     rd_ptr_q;
  logic [W_TMR-1:0]     timer_q;
  logic                 bad_q;
  logic [NB_DATA-1:0]   mem_q [DEPTH];

  logic [NB_DATA-1:0]   o_data_q;
  logic                 o_valid_q;
  logic                 o_sop_q;
  logic                 o_eop_q;
  logic                 o_drop_q;
  logic                 o_overflow_q;
  logic                 o_lost_q;
  logic                 o_timeout_q;
  logic                 o_busy_q;

  logic [W_PTR-1:0]     rd_ptr_d;
  logic                 last_d;

  // Look-ahead on the read pointer so the next word is loaded into the output register on a transfer.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_ONE;
    last_d   = (W_CNT'(rd_ptr_d) == (wr_cnt_q - CNT_ONE));
  end

  // Message state machine, storage writes and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= CNT_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      timer_q      <= TMR_ZERO;
      bad_q        <= 1'b0;
      o_data_q     <= {NB_DATA{1'b0}};
      o_valid_q    <= 1'b0;
      o_sop_q      <= 1'b0;
      o_eop_q      <= 1'b0;
      o_drop_q     <= 1'b0;
      o_overflow_q <= 1'b0;
      o_lost_q     <= 1'b0;
      o_timeout_q  <= 1'b0;
      o_busy_q     <= 1'b0;
    end else begin
      o_drop_q     <= 1'b0;
      o_overflow_q <= 1'b0;
      o_lost_q     <= 1'b0;
      o_timeout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid && i_sop) begin
            mem_q[0] <= i_data;
            wr_cnt_q <= CNT_ONE;
            bad_q    <= 1'b0;
            timer_q  <= TMR_ZERO;
            o_busy_q <= i_eop;
            state_q  <= i_eop ? ST_WAIT_TAG : ST_COLLECT;
          end else if (i_valid) begin
            o_lost_q <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (i_valid && i_sop) begin
            // A fresh sop abandons the partial message and restarts at slot 0.
            o_drop_q <= 1'b1;
            mem_q[0] <= i_data;
            wr_cnt_q <= CNT_ONE;
            bad_q    <= 1'b0;
            timer_q  <= TMR_ZERO;
            o_busy_q <= i_eop;
            state_q  <= i_eop ? ST_WAIT_TAG : ST_COLLECT;
          end else if (i_valid) begin
            if (wr_cnt_q == CNT_DEPTH) begin
              o_overflow_q <= ~bad_q;
              bad_q        <= 1'b1;
            end else begin
              mem_q[wr_cnt_q[W_PTR-1:0]] <= i_data;
              wr_cnt_q                   <= wr_cnt_q + CNT_ONE;
            end
            if (i_eop) begin
              timer_q  <= TMR_ZERO;
              o_busy_q <= 1'b1;
              state_q  <= ST_WAIT_TAG;
            end else begin
              state_q  <= ST_COLLECT;
            end
          end else begin
            state_q <= ST_COLLECT;
          end
        end
        ST_WAIT_TAG: begin
          o_lost_q <= i_valid;
          if (i_tag_valid) begin
            if (i_tag_fail || bad_q) begin
              o_drop_q <= 1'b1;
              state_q  <= ST_DISCARD;
            end else begin
              rd_ptr_q  <= PTR_ZERO;
              o_data_q  <= mem_q[0];
              o_valid_q <= 1'b1;
              o_sop_q   <= 1'b1;
              o_eop_q   <= (wr_cnt_q == CNT_ONE);
              state_q   <= ST_RELEASE;
            end
          end else if (timer_q == TMR_LAST) begin
            o_timeout_q <= 1'b1;
            o_drop_q    <= 1'b1;
            state_q     <= ST_DISCARD;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_RELEASE: begin
          o_lost_q <= i_valid;
          if (o_valid_q && i_ready) begin
            if (o_eop_q) begin
              wr_cnt_q  <= CNT_ZERO;
              rd_ptr_q  <= PTR_ZERO;
              timer_q   <= TMR_ZERO;
              bad_q     <= 1'b0;
              o_data_q  <= {NB_DATA{1'b0}};
              o_valid_q <= 1'b0;
              o_sop_q   <= 1'b0;
              o_eop_q   <= 1'b0;
              o_busy_q  <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_d;
              o_data_q <= mem_q[rd_ptr_d];
              o_sop_q  <= 1'b0;
              o_eop_q  <= last_d;
            end
          end else begin
            state_q <= ST_RELEASE;
          end
        end
        ST_DISCARD: begin
          o_lost_q <= i_valid;
          wr_cnt_q <= CNT_ZERO;
          rd_ptr_q <= PTR_ZERO;
          timer_q  <= TMR_ZERO;
          bad_q    <= 1'b0;
          o_busy_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          o_busy_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_sop      = o_sop_q;
  assign o_eop      = o_eop_q;
  assign o_drop     = o_drop_q;
  assign o_overflow = o_overflow_q;
  assign o_lost     = o_lost_q;
  assign o_timeout  = o_timeout_q;
  assign o_busy     = o_busy_q;

endmodule

// File: tb/tb_gcm_plaintext_release_buffer.sv
// Directed bench for gcm_plaintext_release_buffer: pass, fail, backpressure, overflow,
// lost words, timeout, verdict at expiry, single-word message, abort and mid-release reset.
module tb_gcm_plaintext_release_buffer;

  localparam int NB_DATA = 256;

  logic               clk = 1'b0;
  logic               i_reset;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid, i_sop, i_eop, i_tag_valid, i_tag_fail, i_ready;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid, o_sop, o_eop, o_drop, o_overflow, o_lost, o_timeout, o_busy;

  int errors = 0;
  int checks = 0;

  gcm_plaintext_release_buffer dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_sop      (i_sop),
    .i_eop      (i_eop),
    .i_tag_valid(i_tag_valid),
    .i_tag_fail (i_tag_fail),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_drop     (o_drop),
    .o_overflow (o_overflow),
    .o_lost     (o_lost),
    .o_timeout  (o_timeout),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB_DATA-1:0] dw(input int m, input int k);
    logic [7:0] b;
    b = 8'(m * 16 + k);
    return {32{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NB_DATA-1:0] obs, input logic [NB_DATA-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    i_valid     = 1'b0;
    i_sop       = 1'b0;
    i_eop       = 1'b0;
    i_tag_valid = 1'b0;
    i_tag_fail  = 1'b0;
    i_data      = '0;
  endtask

  task automatic send(input int m, input int k, input logic sop, input logic eop);
    i_valid = 1'b1;
    i_sop   = sop;
    i_eop   = eop;
    i_data  = dw(m, k);
    tick();
    idle_in();
  endtask

  task automatic verdict(input logic fail);
    i_tag_valid = 1'b1;
    i_tag_fail  = fail;
    tick();
    idle_in();
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [NB_DATA-1:0] d,
                         input logic s, input logic e);
    chk({tag, ".valid"}, o_valid, v);
    chk({tag, ".data"},  o_data,  d);
    chk({tag, ".sop"},   o_sop,   s);
    chk({tag, ".eop"},   o_eop,   e);
  endtask

  initial begin
    int idx;
    logic [NB_DATA-1:0] hold;
    logic stalled;
    logic rdy_pat [4];

    idle_in();
    i_ready = 1'b1;
    i_reset = 1'b1;
    tick();
    tick();
    // Reset state: every output zero
    out_chk("rst", 1'b0, '0, 1'b0, 1'b0);
    chk("rst.drop", o_drop, 1'b0);
    chk("rst.ovf",  o_overflow, 1'b0);
    chk("rst.lost", o_lost, 1'b0);
    chk("rst.tmo",  o_timeout, 1'b0);
    chk("rst.busy", o_busy, 1'b0);
    i_reset = 1'b0;

    // Pass: 3 words, verdict two cycles after eop
    send(1, 0, 1'b1, 1'b0);
    chk("pass.busy_collect", o_busy, 1'b0);
    send(1, 1, 1'b0, 1'b0);
    send(1, 2, 1'b0, 1'b1);
    chk("pass.busy_wait", o_busy, 1'b1);
    tick();
    chk("pass.no_early_valid", o_valid, 1'b0);
    verdict(1'b0);
    out_chk("pass.w0", 1'b1, dw(1, 0), 1'b1, 1'b0);
    chk("pass.drop", o_drop, 1'b0);
    tick();
    out_chk("pass.w1", 1'b1, dw(1, 1), 1'b0, 1'b0);
    tick();
    out_chk("pass.w2", 1'b1, dw(1, 2), 1'b0, 1'b1);
    tick();
    chk("pass.done_valid", o_valid, 1'b0);
    chk("pass.done_busy", o_busy, 1'b0);

    // Fail verdict: drop pulse, no output
    send(2, 0, 1'b1, 1'b0);
    send(2, 1, 1'b0, 1'b0);
    send(2, 2, 1'b0, 1'b1);
    tick();
    verdict(1'b1);
    chk("fail.drop", o_drop, 1'b1);
    chk("fail.valid", o_valid, 1'b0);
    chk("fail.busy", o_busy, 1'b1);
    tick();
    chk("fail.drop_end", o_drop, 1'b0);
    chk("fail.busy_end", o_busy, 1'b0);
    chk("fail.valid_end", o_valid, 1'b0);

    // Stray non-sop word in IDLE is lost
    send(9, 0, 1'b0, 1'b0);
    chk("idle.lost", o_lost, 1'b1);
    chk("idle.busy", o_busy, 1'b0);
    tick();
    chk("idle.lost_end", o_lost, 1'b0);

    // Backpressure: 4 words, i_ready pattern 1,0,0,1 repeating
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    for (int k = 0; k < 4; k++) send(3, k, k == 0, k == 3);
    verdict(1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      i_ready = rdy_pat[c % 4];
      stalled = 1'b0;
      chk($sformatf("bp.valid%0d", c), o_valid, 1'b1);
      if (i_ready) begin
        chk($sformatf("bp.data%0d", idx), o_data, dw(3, idx));
        chk($sformatf("bp.sop%0d", idx), o_sop, idx == 0);
        chk($sformatf("bp.eop%0d", idx), o_eop, idx == 3);
        idx++;
      end else begin
        stalled = 1'b1;
        hold    = o_data;
      end
      tick();
      if (stalled) chk($sformatf("bp.stable%0d", c), o_data, hold);
    end
    i_ready = 1'b1;
    chk("bp.count", 32'(idx), 32'd4);
    chk("bp.done_valid", o_valid, 1'b0);

    // Overflow: 18-word message, pulse only on word 17, then lost word in WAIT_TAG
    for (int k = 0; k < 18; k++) begin
      send(4, k, k == 0, k == 17);
      chk($sformatf("ovf.w%0d", k), o_overflow, k == 16);
    end
    chk("ovf.busy", o_busy, 1'b1);
    send(4, 15, 1'b0, 1'b0);
    chk("wait.lost", o_lost, 1'b1);
    tick();
    chk("wait.lost_end", o_lost, 1'b0);
    verdict(1'b0);
    chk("ovf.drop", o_drop, 1'b1);
    chk("ovf.valid", o_valid, 1'b0);
    tick();
    chk("ovf.valid_end", o_valid, 1'b0);
    chk("ovf.busy_end", o_busy, 1'b0);

    // Timeout: no verdict for TAG_TIMEOUT cycles
    send(5, 0, 1'b1, 1'b0);
    send(5, 1, 1'b0, 1'b1);
    repeat (63) tick();
    chk("tmo.not_yet", o_timeout, 1'b0);
    chk("tmo.busy", o_busy, 1'b1);
    tick();
    chk("tmo.pulse", o_timeout, 1'b1);
    chk("tmo.drop", o_drop, 1'b1);
    chk("tmo.valid", o_valid, 1'b0);
    tick();
    chk("tmo.pulse_end", o_timeout, 1'b0);
    chk("tmo.busy_end", o_busy, 1'b0);

    // Verdict exactly at expiry on a single-word message
    send(6, 0, 1'b1, 1'b1);
    repeat (63) tick();
    verdict(1'b0);
    out_chk("exp.w0", 1'b1, dw(6, 0), 1'b1, 1'b1);
    chk("exp.tmo", o_timeout, 1'b0);
    chk("exp.drop", o_drop, 1'b0);
    tick();
    chk("exp.done", o_valid, 1'b0);

    // Abort: sop during COLLECT drops the partial message
    send(7, 0, 1'b1, 1'b0);
    send(7, 1, 1'b0, 1'b0);
    send(7, 2, 1'b1, 1'b1);
    chk("abort.drop", o_drop, 1'b1);
    chk("abort.busy", o_busy, 1'b1);
    verdict(1'b0);
    out_chk("abort.w", 1'b1, dw(7, 2), 1'b1, 1'b1);
    tick();

    // Reset in RELEASE after one word, then a normal message
    send(8, 0, 1'b1, 1'b0);
    send(8, 1, 1'b0, 1'b0);
    send(8, 2, 1'b0, 1'b1);
    verdict(1'b0);
    tick();
    out_chk("prerst.w1", 1'b1, dw(8, 1), 1'b0, 1'b0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    out_chk("midrst", 1'b0, '0, 1'b0, 1'b0);
    chk("midrst.drop", o_drop, 1'b0);
    chk("midrst.busy", o_busy, 1'b0);
    send(10, 0, 1'b1, 1'b0);
    send(10, 1, 1'b0, 1'b1);
    verdict(1'b0);
    out_chk("post.w0", 1'b1, dw(10, 0), 1'b1, 1'b0);
    tick();
    out_chk("post.w1", 1'b1, dw(10, 1), 1'b0, 1'b1);
    tick();
    chk("post.done", o_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcm_plaintext_release_buffer.md
Name: gcm_plaintext_release_buffer

Overview:
- Sits directly downstream of the GCM AES decipher stage.
- Buffers one message of decrypted plaintext words until that message's tag verdict arrives.
- Releases the message to the consumer only if authentication passes; discards it otherwise.
- Guarantees unauthenticated plaintext never leaves the crypto core. Provides valid/ready output handshake, overflow detection and verdict timeout.

Parameters:
- NB_BLOCK, 128, bits per AES block.
- N_BLOCKS, 2, blocks per data word.
- NB_DATA, N_BLOCKS*NB_BLOCK, data word width.
- DEPTH, 16, max words per message held (power of 2, >=2).
- TAG_TIMEOUT, 64, cycles allowed in WAIT_TAG before forced discard (>=2).

Ports:
- i_clock, input, 1, clock.
- i_reset, input, 1, synchronous active-high reset.
- i_data, input, NB_DATA, plaintext word from decipher.
- i_valid, input, 1, i_data valid.
- i_sop, input, 1, first word of message (qualified by i_valid).
- i_eop, input, 1, last word of message (qualified by i_valid).
- i_tag_valid, input, 1, tag verdict strobe.
- i_tag_fail, input, 1, verdict value: 1 = tag mismatch (qualified by i_tag_valid).
- i_ready, input, 1, downstream accepts o_data.
- o_data, output, NB_DATA, released plaintext word.
- o_valid, output, 1, o_data valid.
- o_sop, output, 1, first released word.
- o_eop, output, 1, last released word.
- o_drop, output, 1, one-cycle pulse: buffered message discarded.
- o_overflow, output, 1, one-cycle pulse: write beyond DEPTH.
- o_lost, output, 1, one-cycle pulse: i_valid word arrived while not accepting.
- o_timeout, output, 1, one-cycle pulse: verdict timeout.
- o_busy, output, 1, high in WAIT_TAG, RELEASE, DISCARD.

Behaviour:
- Reset: state IDLE; wr_cnt, rd_ptr, timer, bad flag cleared. Every output 0, including o_data. Memory contents are don't-care. Reset mid-message abandons it with no o_drop.
- Storage: DEPTH x NB_DATA register array. wr_cnt is $clog2(DEPTH+1) bits; rd_ptr is $clog2(DEPTH) bits.
- IDLE:
  - i_valid&&i_sop: write mem[0], wr_cnt=1. Go to WAIT_TAG if i_eop, else COLLECT.
  - i_valid without i_sop: o_lost pulse, word ignored.
- COLLECT:
  - i_valid&&!i_sop: write mem[wr_cnt], wr_cnt++.
  - If wr_cnt==DEPTH on such a write: word not stored, o_overflow pulse, bad=1. Further words consumed and ignored until eop.
  - i_valid&&i_eop: go to WAIT_TAG after the write.
  - i_valid&&i_sop: abort current message with o_drop pulse. The new word is written at mem[0], wr_cnt=1, bad=0; stay in COLLECT, or go to WAIT_TAG if i_eop.
  - i_tag_valid in COLLECT is ignored.
- WAIT_TAG:
  - timer increments each cycle from 0.
  - i_tag_valid: go to DISCARD if i_tag_fail||bad, else RELEASE.
  - No verdict and timer==TAG_TIMEOUT-1: o_timeout pulse, go to DISCARD.
  - Verdict in the same cycle as expiry: verdict wins, no o_timeout.
  - i_valid here: o_lost pulse.
- RELEASE:
  - o_valid=1, o_data=mem[rd_ptr], o_sop=(rd_ptr==0), o_eop=(rd_ptr==wr_cnt-1).
  - Advance rd_ptr on o_valid&&i_ready.
  - Transfer with o_eop: clear counters, go to IDLE.
  - o_data, o_sop and o_eop hold stable while o_valid&&!i_ready.
  - i_valid here: o_lost pulse.
- DISCARD: one cycle, o_drop=1, counters and bad cleared, go to IDLE. i_valid here: o_lost pulse.
- Latency: first o_valid occurs in the cycle after the passing i_tag_valid. Throughput is 1 word/cycle with i_ready high.
- A message is accepted from IDLE in the cycle after its release or discard completes.

Test Plan:
- Pass: 3 words D0..D2 (sop on D0, eop on D2), i_tag_valid=1 & i_tag_fail=0 two cycles later, i_ready=1 -> o_valid for 3 consecutive cycles starting the cycle after the verdict; D0 with o_sop, D2 with o_eop; o_drop=0.
- Fail: same message, i_tag_fail=1 -> o_valid never asserted; o_drop pulses once, the cycle after the verdict; o_busy low on the next cycle.
- Backpressure: pass message of 4 words, i_ready toggling 1,0,0,1,... -> words delivered in order exactly once; o_data stable while stalled; o_eop only on word 4.
- Overflow/lost: DEPTH=16, 18-word message then passing verdict -> o_overflow pulse on word 17 only; o_drop after the verdict; no output. A word sent during WAIT_TAG -> o_lost pulse.
- Timeout and edges:
  - No verdict for TAG_TIMEOUT cycles -> o_timeout and o_drop.
  - Verdict exactly at expiry -> release, no o_timeout.
  - Single-word sop+eop message -> released with o_sop=o_eop=1.
- Reset in RELEASE after 1 of 3 words -> next cycle all outputs 0, state IDLE; a following message is processed normally.
